// File: rtl/types_pkg.sv
// Shared types for the direct-mapped data cache: FSM states, address width
// and the 32-bit data bus type.
package types_pkg;

   localparam int DCACHE_ADDR_W = 32;

   typedef logic [31:0] DATA_BUS;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      WRITE
   } dcache_state;

endpackage

// File: rtl/dcache_direct_if.sv
// Pipeline-side and backing-memory-side signals of dcache_direct.
// The slave modport is the cache itself; master is its environment.
interface dcache_direct_if;
   import types_pkg::*;

   logic                     cpu_re;
   logic                     cpu_we;
   logic [DCACHE_ADDR_W-1:0] cpu_addr;
   DATA_BUS                  cpu_wdata;
   logic [3:0]               cpu_be;
   DATA_BUS                  cpu_rdata;
   logic                     stall;

   logic                     mem_req;
   logic                     mem_we;
   logic [DCACHE_ADDR_W-1:0] mem_addr;
   DATA_BUS                  mem_wdata;
   logic [3:0]               mem_be;
   logic                     mem_ack;
   DATA_BUS                  mem_rdata;

   modport slave (
      input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      output cpu_rdata, stall,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport master (
      output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
      input  cpu_rdata, stall,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: one combinational read
// port, a byte-enabled word write port and a tag/valid set port.
module dcache_line_store
   import types_pkg::*;
#(
   parameter  int SETS           = 16,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int TAG_W          = 24,
   localparam int IDX_W          = $clog2(SETS),
   localparam int OFF_W          = $clog2(WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_index,
   input  logic [OFF_W-1:0] rd_offset,
   output DATA_BUS          rd_data,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [OFF_W-1:0] wr_offset,
   input  DATA_BUS          wr_data,
   input  logic [3:0]       wr_be,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_index,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             set_valid
);

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags  [SETS];
   DATA_BUS          words [SETS*WORDS_PER_LINE];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid <= '0;
      else if (set_en) valid[set_index] <= set_valid;
   end

   // NOTE: tag and data arrays have no reset; a line is only trusted through its valid bit.
   always_ff @(posedge clk) begin
      if (set_en) tags[set_index] <= set_tag;
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) words[{wr_index, wr_offset}][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign rd_data  = words[{rd_index, rd_offset}];
   assign rd_tag   = tags[rd_index];
   assign rd_valid = valid[rd_index];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add hit/miss/write counter output ports.
module dcache_direct
   import types_pkg::*;
#(
   parameter int SETS           = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic             clk,
   input  logic             rst,
   dcache_direct_if.slave   bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
   output logic [31:0]      wr_count
`endif
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = DCACHE_ADDR_W - 2 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   dcache_state state, next_state;

   logic [OFF_W-1:0]         beat;
   logic [TAG_W-1:0]         miss_tag;
   logic [IDX_W-1:0]         miss_index;
   logic [DCACHE_ADDR_W-1:0] wr_addr;
   DATA_BUS                  wr_data_q;
   logic [3:0]               wr_be_q;

   logic [OFF_W-1:0] cpu_offset;
   logic [IDX_W-1:0] cpu_index;
   logic [TAG_W-1:0] cpu_tag;
   DATA_BUS          line_data;
   logic [TAG_W-1:0] line_tag;
   logic             line_valid;
   logic             hit;
   logic             refill_last;

   logic             wr_en;
   logic [IDX_W-1:0] wr_index;
   logic [OFF_W-1:0] wr_offset;
   DATA_BUS          wr_data;
   logic [3:0]       wr_be;
   logic             set_en;
   logic [IDX_W-1:0] set_index;
   logic [TAG_W-1:0] set_tag;
   logic             set_valid;

   assign cpu_offset  = bus.cpu_addr[2 +: OFF_W];
   assign cpu_index   = bus.cpu_addr[2 + OFF_W +: IDX_W];
   assign cpu_tag     = bus.cpu_addr[DCACHE_ADDR_W-1 -: TAG_W];
   assign hit         = line_valid && (line_tag == cpu_tag);
   assign refill_last = (state == REFILL) && bus.mem_ack && (beat == LAST_BEAT);

   dcache_line_store #(
      .SETS           (SETS),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (cpu_index),
      .rd_offset (cpu_offset),
      .rd_data   (line_data),
      .rd_tag    (line_tag),
      .rd_valid  (line_valid),
      .wr_en     (wr_en),
      .wr_index  (wr_index),
      .wr_offset (wr_offset),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .set_en    (set_en),
      .set_index (set_index),
      .set_tag   (set_tag),
      .set_valid (set_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
   always_comb begin
      next_state    = state;
      bus.stall     = 1'b0;
      bus.cpu_rdata = '0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      wr_en         = 1'b0;
      wr_index      = cpu_index;
      wr_offset     = cpu_offset;
      wr_data       = bus.cpu_wdata;
      wr_be         = bus.cpu_be;
      set_en        = 1'b0;
      set_index     = cpu_index;
      set_tag       = cpu_tag;
      set_valid     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.cpu_we) begin
               bus.stall  = 1'b1;
               next_state = WRITE;
               wr_en      = hit;
            end else if (bus.cpu_re) begin
               if (hit) begin
                  bus.cpu_rdata = line_data;
               end else begin
                  // The victim is invalidated up front so an aborted refill never looks valid.
                  bus.stall  = 1'b1;
                  next_state = REFILL;
                  set_en     = 1'b1;
               end
            end
         end
         REFILL: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {miss_tag, miss_index, beat, 2'b00};
            bus.mem_be   = 4'hF;
            wr_index     = miss_index;
            wr_offset    = beat;
            wr_data      = bus.mem_rdata;
            wr_be        = 4'hF;
            set_index    = miss_index;
            set_tag      = miss_tag;
            if (bus.mem_ack) begin
               wr_en = 1'b1;
               if (refill_last) begin
                  set_en     = 1'b1;
                  set_valid  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         WRITE: begin
            bus.stall     = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = wr_data_q;
            bus.mem_be    = wr_be_q;
            if (bus.mem_ack) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat       <= '0;
         miss_tag   <= '0;
         miss_index <= '0;
         wr_addr    <= '0;
         wr_data_q  <= '0;
         wr_be_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cpu_we) begin
                  wr_addr   <= bus.cpu_addr & 32'hFFFF_FFFC;
                  wr_data_q <= bus.cpu_wdata;
                  wr_be_q   <= bus.cpu_be;
               end else if (bus.cpu_re && !hit) begin
                  miss_tag   <= cpu_tag;
                  miss_index <= cpu_index;
                  beat       <= '0;
               end
            end
            REFILL: if (bus.mem_ack) beat <= beat + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // The load held through a refill hits on the next cycle; that hit is not a new access.
   logic refill_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refill_done <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         wr_count    <= '0;
      end else begin
         refill_done <= refill_last;
         if (state == IDLE && !bus.cpu_we && bus.cpu_re && hit && !refill_done)
            hit_count <= hit_count + 32'd1;
         if (refill_last)
            miss_count <= miss_count + 32'd1;
         if (state == WRITE && bus.mem_ack)
            wr_count <= wr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed scenarios plus random
// loads/stores against a line-presence model and a backing-memory model.
module tb_dcache_direct;
   import types_pkg::*;

   localparam int SETS = 16;
   localparam int WPL  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_direct_if bus ();

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count, wr_count;
`endif

   dcache_direct #(
      .SETS           (SETS),
      .WORDS_PER_LINE (WPL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wr_count   (wr_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Backing memory: word-addressed store, unwritten words read a fixed hash.
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          lat;
   } mem_txn_t;

   logic [31:0] mem_store [int unsigned];
   mem_txn_t    mem_log [$];
   int          max_lat = 1;

   function automatic logic [31:0] mem_peek(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (mem_store.exists(w)) return mem_store[w];
      return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   bit          prev_req = 1'b0;
   bit          prev_ack = 1'b0;
   int          wait_cnt = 0;
   int          cur_lat  = 1;
   logic [31:0] held_addr, held_wdata, mem_w;
   logic [4:0]  held_ctl;
   mem_txn_t    txn;

   always @(negedge clk) begin
      if (prev_req && !prev_ack) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
         cur_lat  = int'($urandom_range(1, max_lat));
      end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req === 1'b1) begin
         if (prev_req && !prev_ack) begin
            check("mem_hold_addr", bus.mem_addr, held_addr);
            check("mem_hold_wdata", bus.mem_wdata, held_wdata);
            check("mem_hold_ctl", {bus.mem_we, bus.mem_be}, held_ctl);
         end
         held_addr  = bus.mem_addr;
         held_wdata = bus.mem_wdata;
         held_ctl   = {bus.mem_we, bus.mem_be};
         if (wait_cnt >= cur_lat - 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_peek(bus.mem_addr);
            if (bus.mem_we) begin
               mem_w = mem_peek(bus.mem_addr);
               for (int b = 0; b < 4; b++)
                  if (bus.mem_be[b]) mem_w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
               mem_store[{bus.mem_addr[31:2], 2'b00}] = mem_w;
            end
            txn.we   = bus.mem_we;
            txn.addr = bus.mem_addr;
            txn.data = bus.mem_wdata;
            txn.be   = bus.mem_be;
            txn.lat  = wait_cnt + 1;
            mem_log.push_back(txn);
         end
      end
      prev_req = (bus.mem_req === 1'b1);
      prev_ack = bus.mem_ack;
   end

   // Cache model: which tag each set holds, and expected counter values.
   bit          model_valid [SETS];
   int unsigned model_tag   [SETS];
   int          exp_hits   = 0;
   int          exp_misses = 0;
   int          exp_wrs    = 0;

   task automatic model_reset();
      foreach (model_valid[i]) model_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      exp_wrs    = 0;
   endtask

   task automatic do_load(input logic [31:0] a, output logic [31:0] data, output int cycles);
      int          idx;
      int unsigned tg;
      bit          exp_hit;
      int          lat_sum;
      logic [31:0] base;
      idx     = int'((a / (WPL * 4)) % SETS);
      tg      = a / (SETS * WPL * 4);
      exp_hit = model_valid[idx] && (model_tag[idx] == tg);
      base    = a & ~32'(WPL * 4 - 1);
      cycles  = 0;
      lat_sum = 0;
      mem_log.delete();
      @(negedge clk);
      bus.cpu_re    = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = a;
      bus.cpu_wdata = $urandom;
      bus.cpu_be    = 4'($urandom);
      #1;
      while (bus.stall && cycles < 200) begin
         cycles++;
         @(negedge clk);
         #1;
      end
      check("ld_stall_end", bus.stall, 1'b0);
      data = bus.cpu_rdata;
      check("ld_data", data, mem_peek(a));
      if (exp_hit) begin
         check("ld_hit_stall", cycles, 0);
         check("ld_hit_traffic", mem_log.size(), 0);
         exp_hits++;
      end else begin
         check("ld_miss_beats", mem_log.size(), WPL);
         foreach (mem_log[i]) begin
            check("ld_beat_addr", mem_log[i].addr, base + 32'(4 * i));
            check("ld_beat_ctl", {mem_log[i].we, mem_log[i].be}, 5'h0F);
            lat_sum += mem_log[i].lat;
         end
         check("ld_miss_stall", cycles, lat_sum + 1);
         model_valid[idx] = 1'b1;
         model_tag[idx]   = tg;
         exp_misses++;
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int cycles;
      bit acked;
      cycles = 0;
      acked  = 1'b0;
      mem_log.delete();
      @(negedge clk);
      bus.cpu_re    = 1'b0;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_be    = be;
      #1;
      while (!acked && cycles < 200) begin
         if (bus.stall) cycles++;
         acked = bus.mem_ack;
         if (!acked) begin
            @(negedge clk);
            #1;
         end
      end
      check("st_ack_seen", bus.mem_ack, 1'b1);
      @(negedge clk);
      bus.cpu_we = 1'b0;
      #1;
      check("st_stall_release", bus.stall, 1'b0);
      check("st_txns", mem_log.size(), 1);
      if (mem_log.size() == 1) begin
         check("st_addr", mem_log[0].addr, {a[31:2], 2'b00});
         check("st_data", mem_log[0].data, d);
         check("st_ctl", {mem_log[0].we, mem_log[0].be}, {1'b1, be});
         check("st_stall", cycles, mem_log[0].lat + 1);
      end
      exp_wrs++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.cpu_re = 1'b0;
         bus.cpu_we = 1'b0;
         #1;
         check("idle_stall", bus.stall, 1'b0);
         check("idle_req", bus.mem_req, 1'b0);
      end
   endtask

   task automatic reset_mid_refill(input logic [31:0] a);
      int n;
      n = 0;
      mem_log.delete();
      @(negedge clk);
      bus.cpu_re   = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = a;
      #1;
      while (!(bus.mem_req && bus.mem_addr == a + 32'd8) && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("rst_beat2_addr", bus.mem_addr, a + 32'd8);
      #1 rst = 1'b0;
      #1;
      check("rst_req_drop", bus.mem_req, 1'b0);
      check("rst_we_drop", bus.mem_we, 1'b0);
      check("rst_addr_zero", bus.mem_addr, 32'd0);
      bus.cpu_re = 1'b0;
      #1;
      check("rst_stall", bus.stall, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

`ifdef DCACHE_STATS_EN
   task automatic check_stats();
      check("hit_count", hit_count, exp_hits);
      check("miss_count", miss_count, exp_misses);
      check("wr_count", wr_count, exp_wrs);
   endtask
`endif

   initial begin
      #500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, old, a;
      int          cyc;
      rst           = 1'b0;
      bus.cpu_re    = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.cpu_be    = '0;
      model_reset();
      #3;
      check("rst_stall0", bus.stall, 1'b0);
      check("rst_req0", bus.mem_req, 1'b0);
      check("rst_we0", bus.mem_we, 1'b0);
      check("rst_addr0", bus.mem_addr, 32'd0);
      check("rst_wdata0", bus.mem_wdata, 32'd0);
      check("rst_be0", bus.mem_be, 4'd0);
      check("rst_rdata0", bus.cpu_rdata, 32'd0);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif
      @(negedge clk);
      #2 rst = 1'b1;
      idle(1);

      // Cold load then a hit in the same line.
      max_lat = 1;
      do_load(32'h0000_0040, d, cyc);
      check("cold_stall5", cyc, 5);
      do_load(32'h0000_004C, d, cyc);
      check("warm_hit", cyc, 0);

      // Store hit merges the low halfword.
      old = mem_peek(32'h0000_0044);
      do_store(32'h0000_0044, 32'hAABB_CCDD, 4'b0011);
      do_load(32'h0000_0044, d, cyc);
      check("st_merge", d, {old[31:16], 16'hCCDD});
      check("st_merge_hit", cyc, 0);

      // Store miss does not allocate.
      do_store(32'h0000_1000, 32'h1234_5678, 4'hF);
      do_load(32'h0000_1000, d, cyc);
      check("st_miss_noalloc", cyc, 5);

      // Conflict on set 4.
      do_load(32'h0000_0040, d, cyc);
      do_load(32'h0000_0140, d, cyc);
      check("conflict_refill", cyc, 5);
      do_load(32'h0000_0040, d, cyc);
      check("conflict_evict", cyc, 5);
      idle(1);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif

      // Reset in the third refill beat leaves the line invalid.
      reset_mid_refill(32'h0000_0080);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif
      do_load(32'h0000_0080, d, cyc);
      check("post_rst_refill", cyc, 5);

      // Random traffic over a few conflicting sets, variable memory latency.
      max_lat = 3;
      for (int k = 0; k < 150; k++) begin
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0:       idle(1);
            1, 2, 3: do_store(a, $urandom, 4'($urandom));
            default: do_load(a, d, cyc);
         endcase
      end
      idle(2);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
